// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// CPU core (m0) and host loader (m1) share the RAM with bounded-streak fairness.
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_index,
  output logic [DATA_W-1:0] ram_entry,
  input  logic [DATA_W-1:0] ram_entry_out,
  output logic              busy
);

  localparam logic [3:0] BurstLimit = 4'(MAX_BURST);
  localparam logic [3:0] StreakMax  = 4'd15;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  // owner_q is both the current winner and the last-granted requester (0 = m0)
  logic                owner_q, owner_d;
  logic [3:0]          streak_q, streak_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          rvalid_q;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                pick;
  logic                resp_done;

  assign resp_done = (state_q == StResp);

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      streak_q <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Read data is captured in RESP and presented with rvalid on the following cycle
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= {resp_done && owner_q, resp_done && !owner_q};
      if (resp_done && !owner_q) rdata0_q <= ram_entry_out;
      if (resp_done && owner_q)  rdata1_q <= ram_entry_out;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pick     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) pick = (streak_q < BurstLimit) ? owner_q : ~owner_q;
          else                  pick = m1_req;
          if (pick == owner_q) streak_d = (streak_q == StreakMax) ? StreakMax : streak_q + 4'd1;
          else                 streak_d = 4'd1;
          owner_d = pick;
          we_d    = pick ? m1_we    : m0_we;
          addr_d  = pick ? m1_addr  : m0_addr;
          wdata_d = pick ? m1_wdata : m0_wdata;
          state_d = StAccess;
        end
      end
      StAccess: state_d = we_q ? StIdle : StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    m0_gnt    = (state_q == StAccess) && !owner_q;
    m1_gnt    = (state_q == StAccess) && owner_q;
    ram_wr_en = (state_q == StAccess) && we_q;
    ram_index = addr_q;
    ram_entry = wdata_q;
    busy      = (state_q != StIdle);
    m0_rvalid = rvalid_q[0];
    m1_rvalid = rvalid_q[1];
    m0_rdata  = rdata0_q;
    m1_rdata  = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level schedule model (commit cycle -> gnt/+1, rvalid/+3).
module tb_dmem_arbiter;

  logic        CLOCK_50;
  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_wr_en, busy;
  logic [31:0] ram_index, ram_entry, ram_entry_out;

  logic        b_m0_req, b_m1_req, b_m0_we, b_m1_we;
  logic [31:0] b_m0_addr, b_m1_addr, b_m0_wdata, b_m1_wdata;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_ram_wr_en, b_busy;
  logic [31:0] b_ram_index, b_ram_entry, b_ram_entry_out;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .ram_wr_en(ram_wr_en),
    .ram_index(ram_index), .ram_entry(ram_entry), .ram_entry_out(ram_entry_out),
    .busy(busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) dut_b1 (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .m0_req(b_m0_req), .m1_req(b_m1_req), .m0_we(b_m0_we), .m1_we(b_m1_we),
    .m0_addr(b_m0_addr), .m1_addr(b_m1_addr), .m0_wdata(b_m0_wdata), .m1_wdata(b_m1_wdata),
    .m0_gnt(b_m0_gnt), .m1_gnt(b_m1_gnt), .m0_rvalid(b_m0_rvalid), .m1_rvalid(b_m1_rvalid),
    .m0_rdata(b_m0_rdata), .m1_rdata(b_m1_rdata), .ram_wr_en(b_ram_wr_en),
    .ram_index(b_ram_index), .ram_entry(b_ram_entry), .ram_entry_out(b_ram_entry_out),
    .busy(b_busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous RAMs, cleared while reset is held low
  always @(posedge CLOCK_50) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= '0;
      ram_entry_out <= '0;
    end else begin
      if (ram_wr_en) mem_a[ram_index[5:0]] <= ram_entry;
      ram_entry_out <= mem_a[ram_index[5:0]];
    end
  end

  always @(posedge CLOCK_50) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= '0;
      b_ram_entry_out <= '0;
    end else begin
      if (b_ram_wr_en) mem_b[b_ram_index[5:0]] <= b_ram_entry;
      b_ram_entry_out <= mem_b[b_ram_index[5:0]];
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m0_req = 0; m1_req = 0; b_m0_req = 0; b_m1_req = 0;
    repeat (2) @(posedge CLOCK_50);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'h1234_5678;
    tick(); m0_req = 0;
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 5;
    tick(); m0_req = 0;
    tick();
    tick();
    checks++;
    if (m0_rdata !== 32'h1234_5678 || m0_rvalid !== 1'b1)
      $display("FAIL reset_pre: rdata=%h rvalid=%b want 12345678/1", m0_rdata, m0_rvalid);
    rst = 1'b0;
    #2;
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wr_en, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_wr_en, busy});
    end
    checks++;
    if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", m0_rdata, m1_rdata);
    end
    checks++;
    if (ram_index !== 32'h0 || ram_entry !== 32'h0) begin
      errors++;
      $display("FAIL reset_ram_bus: got %h/%h want 0/0", ram_index, ram_entry);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'hDEAD_BEEF;
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, busy} !== 2'b00) begin
      errors++; $display("FAIL wr_sample_cycle: gnt,busy=%b want 00", {m0_gnt, busy});
    end
    tick(); m0_req = 0;
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, m1_gnt, ram_wr_en, busy} !== 4'b1011 || ram_index !== 32'd5 ||
        ram_entry !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_access: flags=%b idx=%h ent=%h want 1011/5/deadbeef",
               {m0_gnt, m1_gnt, ram_wr_en, busy}, ram_index, ram_entry);
    end
    tick();
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, ram_wr_en, busy} !== 3'b000 || ram_index !== 32'd5) begin
      errors++;
      $display("FAIL wr_after: flags=%b idx=%h want 000/5", {m0_gnt, ram_wr_en, busy}, ram_index);
    end
    m1_req = 1; m1_we = 0; m1_addr = 5; m1_wdata = 32'h0;
    tick(); m1_req = 0;
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, m1_gnt, ram_wr_en, busy} !== 4'b0101) begin
      errors++;
      $display("FAIL rd_gnt: flags=%b want 0101", {m0_gnt, m1_gnt, ram_wr_en, busy});
    end
    tick();
    @(negedge CLOCK_50);
    checks++;
    if ({m1_gnt, m1_rvalid, busy} !== 3'b001) begin
      errors++; $display("FAIL rd_resp: flags=%b want 001", {m1_gnt, m1_rvalid, busy});
    end
    tick();
    @(negedge CLOCK_50);
    checks++;
    if ({m1_rvalid, m0_rvalid, busy} !== 3'b100 || m1_rdata !== 32'hDEAD_BEEF ||
        m0_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rd_rvalid: flags=%b m1_rdata=%h m0_rdata=%h want 100/deadbeef/0",
               {m1_rvalid, m0_rvalid, busy}, m1_rdata, m0_rdata);
    end
    tick();
    @(negedge CLOCK_50);
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_hold: rvalid=%b rdata=%h want 0/deadbeef", m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_burst4();
    int k = 0;
    do_reset();
    m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1;
    for (int c = 0; c < 40; c++) begin
      m0_addr = $urandom_range(0, 63); m0_wdata = $urandom;
      m1_addr = $urandom_range(0, 63); m1_wdata = $urandom;
      @(negedge CLOCK_50);
      checks++;
      if (m0_gnt && m1_gnt) begin
        errors++; $display("FAIL burst4_overlap: both gnt at cycle %0d", c);
      end
      if (m0_gnt || m1_gnt) begin
        checks++;
        if (m1_gnt !== 1'(((k / 4) % 2))) begin
          errors++;
          $display("FAIL burst4_order: grant %0d went to m%0d want m%0d", k, m1_gnt, (k / 4) % 2);
        end
        k++;
      end
      tick();
    end
    m0_req = 0; m1_req = 0;
    checks++;
    if (k != 20) begin
      errors++; $display("FAIL burst4_count: got %0d grants want 20", k);
    end
  endtask

  task automatic test_burst1();
    logic [5:0] obs, exp;
    do_reset();
    b_m0_req = 1; b_m0_we = 0; b_m0_addr = 3; b_m0_wdata = 0;
    b_m1_req = 1; b_m1_we = 0; b_m1_addr = 4; b_m1_wdata = 0;
    for (int c = 0; c < 30; c++) begin
      // Transaction j is sampled at 3j, goes to m(j%2), gnt at 3j+1, rvalid at 3j+3
      exp[5] = (c % 3 == 1) && ((c / 3) % 2 == 0);
      exp[4] = (c % 3 == 1) && ((c / 3) % 2 == 1);
      exp[3] = (c >= 3) && (c % 3 == 0) && (((c / 3) - 1) % 2 == 0);
      exp[2] = (c >= 3) && (c % 3 == 0) && (((c / 3) - 1) % 2 == 1);
      exp[1] = 1'b0;
      exp[0] = (c % 3 != 0);
      @(negedge CLOCK_50);
      obs = {b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_ram_wr_en, b_busy};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL burst1_c%0d: got %b want %b", c, obs, exp);
      end
      tick();
    end
    b_m0_req = 0; b_m1_req = 0;
  endtask

  task automatic test_pulse();
    do_reset();
    m1_req = 1; m1_we = 1; m1_addr = 7; m1_wdata = 32'hA5A5_0001;
    @(negedge CLOCK_50);
    tick();
    m1_req = 0; m0_req = 1; m0_we = 1; m0_addr = 8; m0_wdata = 32'h0000_0808;
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01 || ram_index !== 32'd7) begin
      errors++;
      $display("FAIL pulse_m1_gnt: gnt=%b idx=%h want 01/7", {m0_gnt, m1_gnt}, ram_index);
    end
    tick();
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, m1_gnt, busy} !== 3'b000) begin
      errors++; $display("FAIL pulse_idle: flags=%b want 000", {m0_gnt, m1_gnt, busy});
    end
    tick();
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || ram_index !== 32'd8) begin
      errors++;
      $display("FAIL pulse_m0_wait: gnt=%b idx=%h want 10/8", {m0_gnt, m1_gnt}, ram_index);
    end
    tick();
    m0_req = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 9; m0_wdata = 32'h0000_0011;
    m1_req = 1; m1_we = 0; m1_addr = 5; m1_wdata = 32'h0;
    tick();
    m0_req = 0;
    checks++;
    if ({m0_gnt, ram_wr_en} !== 2'b11) begin
      errors++; $display("FAIL mid_pre: gnt,wr=%b want 11", {m0_gnt, ram_wr_en});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({m0_gnt, m1_gnt, ram_wr_en, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_abort: flags=%b want 0000", {m0_gnt, m1_gnt, ram_wr_en, busy});
    end
    @(posedge CLOCK_50);
    #1 rst = 1'b1;
    tick();
    @(negedge CLOCK_50);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL mid_first_arb: gnt=%b want 01", {m0_gnt, m1_gnt});
    end
    tick();
    m1_req = 0;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_resp_abort: busy=%b want 0", busy);
    end
    @(posedge CLOCK_50);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLOCK_50);
      checks++;
      if ({m0_rvalid, m1_rvalid} !== 2'b00 || m1_rdata !== 32'h0) begin
        errors++;
        $display("FAIL mid_no_rvalid_c%0d: rvalid=%b rdata=%h want 00/0",
                 c, {m0_rvalid, m1_rvalid}, m1_rdata);
      end
      tick();
    end
  endtask

  task automatic test_random(input int n);
    logic [5:0]  e_flags [512];
    logic        e_ld    [512];
    logic [31:0] e_idx   [512];
    logic [31:0] e_ent   [512];
    logic [31:0] e_rdv   [512];
    logic [31:0] mdl_mem [64];
    int          gnt_at  [2];
    logic        req_on  [2];
    logic        r_we    [2];
    logic [31:0] r_addr  [2];
    logic [31:0] r_data  [2];
    int          last, streak, free_c, w;
    logic [31:0] cur_idx, cur_ent, rd0, rd1;
    logic [5:0]  obs;
    do_reset();
    for (int i = 0; i < 512; i++) begin
      e_flags[i] = '0; e_ld[i] = 0; e_idx[i] = '0; e_ent[i] = '0; e_rdv[i] = '0;
    end
    for (int i = 0; i < 64; i++) mdl_mem[i] = '0;
    for (int m = 0; m < 2; m++) begin
      gnt_at[m] = -1; req_on[m] = 0; r_we[m] = 0; r_addr[m] = '0; r_data[m] = '0;
    end
    last = 0; streak = 0; free_c = 0;
    cur_idx = '0; cur_ent = '0; rd0 = '0; rd1 = '0;
    for (int c = 0; c < n + 10; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (gnt_at[m] >= 0 && c > gnt_at[m]) begin
          req_on[m] = 0; gnt_at[m] = -1;
        end
        if (!req_on[m] && c < n && $urandom_range(0, 99) < 50) begin
          req_on[m] = 1;
          r_we[m]   = 1'($urandom_range(0, 1));
          r_addr[m] = $urandom_range(0, 15);
          r_data[m] = $urandom;
        end
      end
      m0_req = req_on[0]; m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_data[0];
      m1_req = req_on[1]; m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_data[1];
      if (c >= free_c && (req_on[0] || req_on[1])) begin
        if (req_on[0] && req_on[1]) w = (streak < 4) ? last : 1 - last;
        else                        w = req_on[1] ? 1 : 0;
        streak = (w == last) ? ((streak < 15) ? streak + 1 : 15) : 1;
        last = w;
        gnt_at[w] = c + 1;
        e_flags[c+1][5-w] = 1'b1;
        e_flags[c+1][0]   = 1'b1;
        e_ld[c+1]  = 1'b1;
        e_idx[c+1] = r_addr[w];
        e_ent[c+1] = r_data[w];
        if (r_we[w]) begin
          e_flags[c+1][3] = 1'b1;
          mdl_mem[r_addr[w][5:0]] = r_data[w];
          free_c = c + 2;
        end else begin
          e_flags[c+2][0]   = 1'b1;
          e_flags[c+3][2-w] = 1'b1;
          e_rdv[c+3] = mdl_mem[r_addr[w][5:0]];
          free_c = c + 3;
        end
      end
      @(negedge CLOCK_50);
      if (e_ld[c]) begin
        cur_idx = e_idx[c]; cur_ent = e_ent[c];
      end
      if (e_flags[c][2]) rd0 = e_rdv[c];
      if (e_flags[c][1]) rd1 = e_rdv[c];
      obs = {m0_gnt, m1_gnt, ram_wr_en, m0_rvalid, m1_rvalid, busy};
      checks++;
      if (obs !== e_flags[c]) begin
        errors++; $display("FAIL rand_flags_c%0d: got %b want %b", c, obs, e_flags[c]);
      end
      checks++;
      if (ram_index !== cur_idx || ram_entry !== cur_ent) begin
        errors++;
        $display("FAIL rand_ram_bus_c%0d: got %h/%h want %h/%h",
                 c, ram_index, ram_entry, cur_idx, cur_ent);
      end
      checks++;
      if (m0_rdata !== rd0 || m1_rdata !== rd1) begin
        errors++;
        $display("FAIL rand_rdata_c%0d: got %h/%h want %h/%h", c, m0_rdata, m1_rdata, rd0, rd1);
      end
      tick();
    end
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    rst = 1'b0;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    b_m0_req = 0; b_m1_req = 0; b_m0_we = 0; b_m1_we = 0;
    b_m0_addr = '0; b_m1_addr = '0; b_m0_wdata = '0; b_m1_wdata = '0;
    test_reset();
    test_write_read();
    test_burst4();
    test_burst1();
    test_pulse();
    test_reset_mid();
    test_random(300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
